// File: rtl/dram_pkg.sv
// Shared widths and command payload for the dram_ori request front-end.
package dram_pkg;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dram_cmd_t;

    localparam int unsigned CMD_W = $bits(dram_cmd_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers; the extra pointer bit separates full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + CW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dram_req_ctrl.sv
// In-order request front-end for dram_ori: request FIFO, credit-gated read issue,
// registered array strobes and a back-pressurable read response FIFO.
module dram_req_ctrl
    import dram_pkg::*;
#(
    parameter int unsigned REQ_DEPTH = 4,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          dram_ren,
    output logic          dram_wen,
    output logic [AW-1:0] dram_raddr,
    output logic [AW-1:0] dram_waddr,
    output logic [DW-1:0] dram_wdata,
    input  logic [DW-1:0] dram_rdata,
    output logic          busy
);

    localparam int unsigned CRW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned RQC = $clog2(REQ_DEPTH) + 1;
    localparam int unsigned RSC = $clog2(RSP_DEPTH) + 1;

    dram_cmd_t       req_cmd;
    dram_cmd_t       head;
    logic            req_full, req_empty, req_push, req_pop;
    logic [RQC-1:0]  req_count;
    logic            rsp_full, rsp_empty, rsp_push, rsp_pop;
    logic [RSC-1:0]  rsp_count;
    logic            issue_wr, issue_rd;

    logic [CRW-1:0]    credit_q, credit_d;
    logic [RD_LAT-1:0] inflight_q, inflight_d;
    logic              dram_ren_q, dram_ren_d;
    logic              dram_wen_q, dram_wen_d;
    logic [AW-1:0]     dram_raddr_q, dram_raddr_d;
    logic [AW-1:0]     dram_waddr_q, dram_waddr_d;
    logic [DW-1:0]     dram_wdata_q, dram_wdata_d;

    assign req_cmd  = {req_we, req_addr, req_wdata};
    assign req_push = req_valid & ~req_full;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_push),
        .din   (req_cmd),
        .pop   (req_pop),
        .dout  (head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    assign rsp_push = inflight_q[RD_LAT-1];
    assign rsp_pop  = rsp_ready & ~rsp_empty;

    sync_fifo #(.WIDTH(DW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .din   (dram_rdata),
        .pop   (rsp_pop),
        .dout  (rsp_data),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    // Head-of-line issue: a read without a credit blocks everything behind it.
    assign issue_wr = ~req_empty & head.we;
    assign issue_rd = ~req_empty & ~head.we & (credit_q != '0);
    assign req_pop  = issue_wr | issue_rd;

    always_comb begin
        credit_d      = credit_q - CRW'(issue_rd) + CRW'(rsp_pop);
        inflight_d    = inflight_q;
        inflight_d[0] = dram_ren_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
        dram_wen_d   = issue_wr;
        dram_ren_d   = issue_rd;
        dram_waddr_d = issue_wr ? head.addr  : dram_waddr_q;
        dram_wdata_d = issue_wr ? head.wdata : dram_wdata_q;
        dram_raddr_d = issue_rd ? head.addr  : dram_raddr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q     <= CRW'(RSP_DEPTH);
            inflight_q   <= '0;
            dram_ren_q   <= 1'b0;
            dram_wen_q   <= 1'b0;
            dram_raddr_q <= '0;
            dram_waddr_q <= '0;
            dram_wdata_q <= '0;
        end else begin
            credit_q     <= credit_d;
            inflight_q   <= inflight_d;
            dram_ren_q   <= dram_ren_d;
            dram_wen_q   <= dram_wen_d;
            dram_raddr_q <= dram_raddr_d;
            dram_waddr_q <= dram_waddr_d;
            dram_wdata_q <= dram_wdata_d;
        end
    end

    // Credits reserve a response slot per issued read, so a full rsp FIFO never sees a push.
    a_no_rsp_overflow: assert property (@(posedge clk) disable iff (rst) !(rsp_push && rsp_full));

    assign req_ready  = ~req_full;
    assign rsp_valid  = ~rsp_empty;
    assign dram_ren   = dram_ren_q;
    assign dram_wen   = dram_wen_q;
    assign dram_raddr = dram_raddr_q;
    assign dram_waddr = dram_waddr_q;
    assign dram_wdata = dram_wdata_q;
    assign busy       = (req_count != '0) | dram_ren_q | (|inflight_q) | (rsp_count != '0);

endmodule

// File: tb/tb_dram_req_ctrl.sv
// Scoreboard bench for dram_req_ctrl with a behavioural single-cycle-latency array model.
module tb_dram_req_ctrl;
    import dram_pkg::*;

    localparam int unsigned MEMN = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          dram_ren, dram_wen;
    logic [AW-1:0] dram_raddr, dram_waddr;
    logic [DW-1:0] dram_wdata, dram_rdata;
    logic          busy;

    always #5 clk = ~clk;

    dram_req_ctrl #(.REQ_DEPTH(4), .RSP_DEPTH(4), .RD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .dram_ren   (dram_ren),
        .dram_wen   (dram_wen),
        .dram_raddr (dram_raddr),
        .dram_waddr (dram_waddr),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .busy       (busy)
    );

    // Array stand-in: write at the strobe edge, read data valid one cycle after dram_ren.
    bit [DW-1:0] mem [MEMN];
    always @(posedge clk) begin
        if (dram_wen) mem[dram_waddr[9:0]] <= dram_wdata;
        if (dram_ren) dram_rdata <= mem[dram_raddr[9:0]];
    end

    int checks = 0, failures = 0;
    int cyc = 0;
    int ren_cnt = 0, wen_cnt = 0, rsp_cnt = 0;
    int last_wen_cyc = 0, last_ren_cyc = 0;
    int rsp_cyc [$];

    bit [DW-1:0]         ref_mem [MEMN];
    logic [AW+DW-1:0]    exp_wr  [$];
    logic [AW-1:0]       exp_rd  [$];
    logic [DW-1:0]       exp_rsp [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference model: commands take effect in acceptance order, so a read sees every earlier write.
    always @(negedge clk) begin
        if (rst) begin
            exp_wr.delete();
            exp_rd.delete();
            exp_rsp.delete();
        end else begin
            if (req_valid && req_ready) begin
                if (req_we) begin
                    ref_mem[req_addr[9:0]] = req_wdata;
                    exp_wr.push_back({req_addr, req_wdata});
                end else begin
                    exp_rd.push_back(req_addr);
                    exp_rsp.push_back(ref_mem[req_addr[9:0]]);
                end
            end
            if (dram_wen || dram_ren) check("strobe_excl", 32'(dram_wen & dram_ren), 32'h0);
            if (dram_wen) begin
                wen_cnt++;
                last_wen_cyc = cyc;
                if (exp_wr.size() == 0) fail_now("wen_unexpected");
                else check("wr_addr_data", 32'({dram_waddr, dram_wdata}), 32'(exp_wr.pop_front()));
            end
            if (dram_ren) begin
                ren_cnt++;
                last_ren_cyc = cyc;
                if (exp_rd.size() == 0) fail_now("ren_unexpected");
                else check("rd_addr", 32'(dram_raddr), 32'(exp_rd.pop_front()));
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                rsp_cyc.push_back(cyc);
                if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
                else check("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            tick();
        end
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic req_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            done = !busy && exp_rsp.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0;
        end
        if (!done) fail_now("drain_timeout");
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c0, ren0, wen0, rc0;
        bit seen_valid, rnd_on;
        rst = 1'b1; rsp_ready = 1'b0; req_addr = '0; req_wdata = '0;
        req_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_ren",       32'(dram_ren),  32'h0);
        check("rst_wen",       32'(dram_wen),  32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_raddr",     32'(dram_raddr), 32'h0);
        tick();

        // Write then read the same address: cycle-exact latency
        rsp_ready = 1'b1;
        rsp_cyc.delete();
        c0 = cyc;
        send(1'b1, 20'h00005, 8'hA5);
        send(1'b0, 20'h00005, 8'h00);
        req_idle();
        drain();
        check("lat_wen", 32'(last_wen_cyc - c0), 32'd2);
        check("lat_ren", 32'(last_ren_cyc - c0), 32'd3);
        check("lat_rsp_n", 32'(rsp_cyc.size()), 32'd1);
        if (rsp_cyc.size() == 1) check("lat_rsp", 32'(rsp_cyc[0] - c0), 32'd5);

        // Back-to-back reads produce consecutive response beats
        rsp_cyc.delete();
        for (int i = 0; i < 3; i++) send(1'b1, AW'(i), DW'(8'h10 + i));
        for (int i = 0; i < 3; i++) send(1'b0, AW'(i), 8'h00);
        req_idle();
        drain();
        check("b2b_beats", 32'(rsp_cyc.size()), 32'd3);
        if (rsp_cyc.size() == 3) begin
            check("b2b_gap0", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd1);
            check("b2b_gap1", 32'(rsp_cyc[2] - rsp_cyc[1]), 32'd1);
        end

        // Credit exhaustion under response back-pressure
        for (int i = 0; i < 10; i++) send(1'b1, AW'(100 + i), DW'($urandom));
        req_idle();
        drain();
        rsp_ready = 1'b0;
        ren0 = ren_cnt;
        rc0  = rsp_cnt;
        fork
            begin
                for (int i = 0; i < 10; i++) send(1'b0, AW'(100 + i), 8'h00);
                req_idle();
            end
            begin
                repeat (25) @(posedge clk);
                @(negedge clk);
                check("credit_ren_cnt", 32'(ren_cnt - ren0), 32'd4);
                check("credit_req_ready", 32'(req_ready), 32'h0);
                check("credit_rsp_valid", 32'(rsp_valid), 32'h1);
                check("credit_no_pop", 32'(rsp_cnt - rc0), 32'd0);
                tick();
                rsp_ready = 1'b1;
            end
        join
        drain();
        check("credit_all_back", 32'(rsp_cnt - rc0), 32'd10);

        // Reset while a read is in flight
        send(1'b1, 20'd200, 8'h3C);
        send(1'b0, 20'd200, 8'h00);
        req_idle();
        begin
            bit got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = dram_ren;
            end
            if (!got) fail_now("rst_ren_timeout");
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rc0 = rsp_cnt;
        seen_valid = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_rsp", 32'(seen_valid), 32'h0);
        tick();
        send(1'b0, 20'd200, 8'h00);
        req_idle();
        drain();
        check("midrst_next_read", 32'(rsp_cnt - rc0), 32'd1);

        // Full request FIFO while the head pops: held command enters next cycle
        rsp_ready = 1'b0;
        wen0 = wen_cnt;
        fork
            begin
                for (int i = 0; i < 5; i++) send(1'b0, AW'(300 + i), 8'h00);
                for (int i = 0; i < 3; i++) send(1'b1, AW'(400 + i), DW'($urandom));
                send(1'b1, 20'd500, 8'h77);
                req_idle();
            end
            begin
                bit prev_ready, got;
                repeat (20) @(posedge clk);
                @(negedge clk);
                check("full_req_ready", 32'(req_ready), 32'h0);
                tick();
                rsp_ready = 1'b1;
                prev_ready = 1'b1;
                got = 1'b0;
                for (int i = 0; i < 20 && !got; i++) begin
                    @(negedge clk);
                    if (dram_ren) begin
                        got = 1'b1;
                        check("full_pop_ready", 32'(prev_ready), 32'h0);
                        check("full_next_ready", 32'(req_ready), 32'h1);
                    end
                    prev_ready = req_ready;
                end
                if (!got) fail_now("full_ren_timeout");
            end
        join
        drain();
        check("full_writes", 32'(wen_cnt - wen0), 32'd4);
        rc0 = rsp_cnt;
        send(1'b0, 20'd500, 8'h00);
        req_idle();
        drain();
        check("full_readback", 32'(rsp_cnt - rc0), 32'd1);

        // Random mix with random response back-pressure
        rnd_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_idle();
                        repeat ($urandom_range(1, 2)) tick();
                    end
                    send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
                end
                req_idle();
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        rsp_ready = 1'b1;
        drain();
        check("rand_idle_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
